// File: rtl/ama_riscv_trace_buffer.sv
// Commit trace buffer: captures one record per retired instruction into a
// first-word-fall-through FIFO, drains it over valid/ready, and keeps
// saturating event counters plus a sticky overflow flag.
module ama_riscv_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int ARCH_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [INST_WIDTH-1:0]   in_inst,
  input  logic [ARCH_WIDTH-1:0]   in_pc,
  input  logic                    in_branch_inst,
  input  logic                    in_branch_taken,
  input  logic [ARCH_WIDTH-1:0]   in_dmem_addr,
  input  logic [3:0]              in_dmem_size,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        out_seq,
  output logic [INST_WIDTH-1:0]   out_inst,
  output logic [ARCH_WIDTH-1:0]   out_pc,
  output logic [ARCH_WIDTH-1:0]   out_dmem_addr,
  output logic [3:0]              out_dmem_size,
  output logic                    out_branch_inst,
  output logic                    out_branch_taken,
  output logic [CNT_W-1:0]        cnt_retired,
  output logic [CNT_W-1:0]        cnt_branch,
  output logic [CNT_W-1:0]        cnt_taken,
  output logic [CNT_W-1:0]        cnt_load,
  output logic [CNT_W-1:0]        cnt_store,
  output logic [CNT_W-1:0]        cnt_dropped,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ARCH_WIDTH-1:0] pc;
    logic                  br;
    logic                  tk;
    logic [ARCH_WIDTH-1:0] addr;
    logic [3:0]            size;
    logic [CNT_W-1:0]      seq;
  } rec_t;

  rec_t mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] ret_q, ret_d, br_q, br_d, tk_q, tk_d;
  logic [CNT_W-1:0] ld_q, ld_d, st_q, st_d, drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic full, pop, push, drop, is_load, is_store;
  rec_t rec_in, head;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign full      = (level_q == LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;
  assign is_load   = (in_dmem_size < 4'd4);
  assign is_store  = (in_dmem_size[3:2] == 2'b01);

  assign rec_in = '{inst: in_inst, pc: in_pc, br: in_branch_inst,
                    tk: in_branch_taken, addr: in_dmem_addr,
                    size: in_dmem_size, seq: seq_q};

  assign head             = mem_q[rd_ptr_q];
  assign out_seq          = head.seq;
  assign out_inst         = head.inst;
  assign out_pc           = head.pc;
  assign out_dmem_addr    = head.addr;
  assign out_dmem_size    = head.size;
  assign out_branch_inst  = head.br;
  assign out_branch_taken = head.tk;

  assign cnt_retired = ret_q;
  assign cnt_branch  = br_q;
  assign cnt_taken   = tk_q;
  assign cnt_load    = ld_q;
  assign cnt_store   = st_q;
  assign cnt_dropped = drop_q;
  assign overflow    = ovf_q;
  assign level       = level_q;

  // Next-state: clr wins over everything; otherwise pointers, occupancy,
  // sequence number and event counters advance on push/pop/retire.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    seq_d    = seq_q;
    ret_d    = ret_q;
    br_d     = br_q;
    tk_d     = tk_q;
    ld_d     = ld_q;
    st_d     = st_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      seq_d    = '0;
      ret_d    = '0;
      br_d     = '0;
      tk_d     = '0;
      ld_d     = '0;
      st_d     = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (in_valid) seq_d = seq_q + CNT_W'(1);
      ret_d  = sat_inc(ret_q,  in_valid);
      br_d   = sat_inc(br_q,   in_valid && in_branch_inst);
      tk_d   = sat_inc(tk_q,   in_valid && in_branch_inst && in_branch_taken);
      ld_d   = sat_inc(ld_q,   in_valid && is_load);
      st_d   = sat_inc(st_q,   in_valid && is_store);
      drop_d = sat_inc(drop_q, drop);
      if (drop) ovf_d = 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      ret_q    <= '0;
      br_q     <= '0;
      tk_q     <= '0;
      ld_q     <= '0;
      st_q     <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      ret_q    <= ret_d;
      br_q     <= br_d;
      tk_q     <= tk_d;
      ld_q     <= ld_d;
      st_q     <= st_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Record storage, deliberately left unreset; only valid entries are read.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= rec_in;
  end

endmodule

// File: tb/tb_ama_riscv_trace_buffer.sv
// Bench for the commit trace buffer: two instances (32-bit and 4-bit
// counters) see the same stimulus and are compared against a queue model.
module tb_ama_riscv_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst = 0, in_pc = 0, in_dmem_addr = 0;
  logic [3:0]  in_dmem_size = 8;
  logic        in_branch_inst = 0, in_branch_taken = 0;

  logic        a_valid, a_br, a_tk, a_ovf;
  logic [31:0] a_seq, a_inst, a_pc, a_addr;
  logic [3:0]  a_size;
  logic [31:0] a_ret, a_brc, a_tkc, a_ld, a_st, a_drop;
  logic [4:0]  a_level;

  logic        b_valid, b_br, b_tk, b_ovf;
  logic [3:0]  b_seq;
  logic [31:0] b_inst, b_pc, b_addr;
  logic [3:0]  b_size;
  logic [3:0]  b_ret, b_brc, b_tkc, b_ld, b_st, b_drop;
  logic [4:0]  b_level;

  ama_riscv_trace_buffer #(.DEPTH(DEPTH), .CNT_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_inst(in_inst),
    .in_pc(in_pc), .in_branch_inst(in_branch_inst), .in_branch_taken(in_branch_taken),
    .in_dmem_addr(in_dmem_addr), .in_dmem_size(in_dmem_size),
    .out_valid(a_valid), .out_ready(out_ready), .out_seq(a_seq), .out_inst(a_inst),
    .out_pc(a_pc), .out_dmem_addr(a_addr), .out_dmem_size(a_size),
    .out_branch_inst(a_br), .out_branch_taken(a_tk),
    .cnt_retired(a_ret), .cnt_branch(a_brc), .cnt_taken(a_tkc), .cnt_load(a_ld),
    .cnt_store(a_st), .cnt_dropped(a_drop), .overflow(a_ovf), .level(a_level));

  ama_riscv_trace_buffer #(.DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_inst(in_inst),
    .in_pc(in_pc), .in_branch_inst(in_branch_inst), .in_branch_taken(in_branch_taken),
    .in_dmem_addr(in_dmem_addr), .in_dmem_size(in_dmem_size),
    .out_valid(b_valid), .out_ready(out_ready), .out_seq(b_seq), .out_inst(b_inst),
    .out_pc(b_pc), .out_dmem_addr(b_addr), .out_dmem_size(b_size),
    .out_branch_inst(b_br), .out_branch_taken(b_tk),
    .cnt_retired(b_ret), .cnt_branch(b_brc), .cnt_taken(b_tkc), .cnt_load(b_ld),
    .cnt_store(b_st), .cnt_dropped(b_drop), .overflow(b_ovf), .level(b_level));

  always #5 clk = ~clk;

  // Reference model: unbounded counts, saturation/wrap applied when comparing.
  typedef struct {
    logic [31:0] inst, pc, addr;
    logic [3:0]  size;
    logic        br, tk;
    longint      seq;
  } mrec_t;

  mrec_t  mq[$];
  longint m_seq, m_ret, m_br, m_tk, m_ld, m_st, m_drop;
  bit     m_ovf;
  int     n_chk = 0, n_fail = 0;

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_seq = 0; m_ret = 0; m_br = 0; m_tk = 0; m_ld = 0; m_st = 0; m_drop = 0;
    m_ovf = 0;
  endtask

  // Apply the retire/drain rules to the model for the upcoming clock edge.
  task automatic model_step();
    int    sz;
    bit    pop, full;
    mrec_t r;
    sz   = mq.size();
    pop  = (sz != 0) && out_ready;
    full = (sz == DEPTH);
    if (clr) begin
      model_clear();
    end else begin
      if (pop) void'(mq.pop_front());
      if (in_valid) begin
        if (!full || pop) begin
          r.inst = in_inst; r.pc = in_pc; r.addr = in_dmem_addr;
          r.size = in_dmem_size; r.br = in_branch_inst; r.tk = in_branch_taken;
          r.seq = m_seq;
          mq.push_back(r);
        end else begin
          m_drop++;
          m_ovf = 1;
        end
        m_seq++;
        m_ret++;
        if (in_branch_inst) m_br++;
        if (in_branch_inst && in_branch_taken) m_tk++;
        if (in_dmem_size < 4) m_ld++;
        else if (in_dmem_size < 8) m_st++;
      end
    end
  endtask

  task automatic check_all();
    chk("a_valid", a_valid, mq.size() != 0);
    chk("b_valid", b_valid, mq.size() != 0);
    chk("a_level", a_level, mq.size());
    chk("b_level", b_level, mq.size());
    chk("a_ovf", a_ovf, m_ovf);
    chk("b_ovf", b_ovf, m_ovf);
    chk("a_ret", a_ret, sat(m_ret, 32));   chk("b_ret", b_ret, sat(m_ret, 4));
    chk("a_br", a_brc, sat(m_br, 32));     chk("b_br", b_brc, sat(m_br, 4));
    chk("a_tk", a_tkc, sat(m_tk, 32));     chk("b_tk", b_tkc, sat(m_tk, 4));
    chk("a_ld", a_ld, sat(m_ld, 32));      chk("b_ld", b_ld, sat(m_ld, 4));
    chk("a_st", a_st, sat(m_st, 32));      chk("b_st", b_st, sat(m_st, 4));
    chk("a_drop", a_drop, sat(m_drop, 32)); chk("b_drop", b_drop, sat(m_drop, 4));
    if (mq.size() != 0) begin
      chk("a_seq", a_seq, mq[0].seq % (longint'(1) << 32));
      chk("b_seq", b_seq, mq[0].seq % 16);
      chk("a_inst", a_inst, mq[0].inst);  chk("b_inst", b_inst, mq[0].inst);
      chk("a_pc", a_pc, mq[0].pc);        chk("b_pc", b_pc, mq[0].pc);
      chk("a_addr", a_addr, mq[0].addr);  chk("b_addr", b_addr, mq[0].addr);
      chk("a_size", a_size, mq[0].size);  chk("b_size", b_size, mq[0].size);
      chk("a_brf", a_br, mq[0].br);       chk("b_brf", b_br, mq[0].br);
      chk("a_tkf", a_tk, mq[0].tk);       chk("b_tkf", b_tk, mq[0].tk);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rnd_rec();
    in_inst         = $urandom;
    in_pc           = $urandom & 32'hffff_fffc;
    in_branch_inst  = 1'($urandom_range(0, 1));
    in_branch_taken = 1'($urandom_range(0, 1));
    in_dmem_size    = 4'($urandom_range(0, 15));
    in_dmem_addr    = (in_dmem_size == 4'd8) ? 32'h0 : $urandom;
  endtask

  task automatic retire(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; out_ready = rdy; rnd_rec();
      tick();
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n, input logic rdy);
    in_valid = 0; out_ready = rdy;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clr();
    clr = 1; tick(); clr = 0;
  endtask

  task automatic dir_rec(input logic [3:0] sz, input logic br, input logic tk);
    in_valid = 1; rnd_rec();
    in_dmem_size = sz; in_branch_inst = br; in_branch_taken = tk;
    tick();
    in_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 0;

    // Single retire
    in_valid = 1; out_ready = 0; in_pc = 32'h40; in_inst = 32'h0050_0093;
    in_dmem_size = 8; in_dmem_addr = 0; in_branch_inst = 0; in_branch_taken = 0;
    tick();
    in_valid = 0;
    chk("single_valid", a_valid, 1'b1);
    chk("single_seq", a_seq, 0);
    chk("single_pc", a_pc, 32'h40);
    chk("single_inst", a_inst, 32'h0050_0093);
    chk("single_ret", a_ret, 1);
    idle(2, 1);

    // Backpressure fill with drops, then in-order drain
    do_clr();
    retire(20, 0);
    chk("fill_level", a_level, 16);
    chk("fill_drop", a_drop, 4);
    chk("fill_ovf", a_ovf, 1'b1);
    chk("fill_ret", a_ret, 20);
    idle(17, 1);

    // Full with simultaneous pop: accepted, level stays full
    retire(16, 0);
    retire(1, 1);
    chk("fullpop_level", a_level, 16);
    chk("fullpop_drop", a_drop, 4);
    idle(17, 1);

    // Event mix
    do_clr();
    out_ready = 1;
    dir_rec(4'd2, 0, 0);
    dir_rec(4'd4, 0, 0);
    dir_rec(4'd8, 1, 1);
    dir_rec(4'd8, 1, 0);
    chk("mix_ld", a_ld, 1);
    chk("mix_st", a_st, 1);
    chk("mix_br", a_brc, 2);
    chk("mix_tk", a_tkc, 1);
    idle(2, 1);

    // Seq wrap / counter saturation on the narrow instance
    do_clr();
    retire(20, 1);
    chk("sat_ret4", b_ret, 4'hf);
    idle(2, 1);

    // Random traffic with occasional clr
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 1) == 1);
      clr       = ($urandom_range(0, 99) < 2);
      rnd_rec();
      tick();
    end
    clr = 0; in_valid = 0;
    idle(20, 1);

    // clr together with a retire while holding five records
    do_clr();
    retire(5, 0);
    chk("pre_clr_level", a_level, 5);
    in_valid = 1; clr = 1; out_ready = 1; rnd_rec();
    tick();
    clr = 0; in_valid = 0;
    chk("clr_level", a_level, 0);
    chk("clr_valid", a_valid, 1'b0);
    chk("clr_ret", a_ret, 0);

    // Asynchronous reset mid-drain
    retire(3, 0);
    out_ready = 1;
    tick();
    #2;
    rst = 1;
    #1;
    model_clear();
    chk("arst_valid", a_valid, 1'b0);
    chk("arst_level", a_level, 0);
    chk("arst_ret", a_ret, 0);
    @(posedge clk);
    #1;
    rst = 0;
    idle(2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
